// File: rtl/keypad_hex_entry_pkg.sv
// Shared types and constants for the keypad hex entry block.
// Segment codes are active-low, with bit 7 as dp and bits 6:0 as g..a.
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CAND,
    HELD
  } state_t;

  localparam logic [7:0] SEG_BLANK  = 8'hFF;
  localparam logic [2:0] MAX_DIGITS = 3'd4;

  // Entry [d] is the glyph for hex digit d; b and d are lowercase.
  localparam logic [15:0][7:0] SEG_LUT = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

endpackage

// File: rtl/keypad_hex_entry_if.sv
// Connects the scanner and operand-select side to the entry block.
// The segment display and operand-register outputs travel on the same bundle.
interface keypad_hex_entry_if;
  logic        scan_done;
  logic        key_hit;
  logic [3:0]  key_code;
  logic        operand_sel;
  logic        clr;
  logic        key_accept;
  logic [3:0]  key_out;
  logic        ovf;
  logic [15:0] num1;
  logic [15:0] num2;
  logic [2:0]  cnt1;
  logic [2:0]  cnt2;
  logic [31:0] seg_out;

  modport master (
    output scan_done, key_hit, key_code, operand_sel, clr,
    input  key_accept, key_out, ovf, num1, num2, cnt1, cnt2, seg_out
  );

  modport slave (
    input  scan_done, key_hit, key_code, operand_sel, clr,
    output key_accept, key_out, ovf, num1, num2, cnt1, cnt2, seg_out
  );
endinterface

// File: rtl/keypad_hex_entry_hex_to_7seg.sv
// Converts one hex digit into the segment pattern for an active-low display.
module hex_to_7seg
  import keypad_pkg::*;
(
  input  logic [3:0] hex,
  output logic [7:0] seg
);

  assign seg = SEG_LUT[hex];

endmodule

// File: rtl/keypad_hex_entry.sv
// Debounces keypad scan results, shifts accepted digits into two operands, and drives the display.
//   state | meaning
//   IDLE  | no key pressed; waiting for a hit
//   CAND  | a candidate code is being confirmed over consecutive scans
//   HELD  | the digit has been accepted; waiting for the release to be confirmed
module keypad_hex_entry
  import keypad_pkg::*;
#(
  parameter int unsigned DEBOUNCE_SCANS = 3,
  parameter int unsigned RELEASE_SCANS  = 2
) (
  input  logic                clk,
  input  logic                rst,
  keypad_hex_entry_if.slave   bus
);

  localparam logic [3:0] DEB_TC = 4'(DEBOUNCE_SCANS);
  localparam logic [3:0] REL_TC = 4'(RELEASE_SCANS);

  state_t      state_q, state_n;
  logic [3:0]  cand_q, cand_n;
  logic [3:0]  stab_q, stab_n;
  logic [3:0]  rel_q, rel_n;
  logic        accept;

  logic        key_accept_q, ovf_q, ovf_n;
  logic [3:0]  key_out_q;
  logic [15:0] num1_q, num2_q, num1_n, num2_n;
  logic [2:0]  cnt1_q, cnt2_q, cnt1_n, cnt2_n;
  logic [31:0] seg_q, seg_n;

  logic [15:0] act_num, act_num_n;
  logic [2:0]  act_cnt, act_cnt_n;
  logic [7:0]  seg_raw [4];

  always_comb begin
    state_n = state_q;
    cand_n  = cand_q;
    stab_n  = stab_q;
    rel_n   = rel_q;
    accept  = 1'b0;
    if (bus.scan_done) begin
      unique case (state_q)
        IDLE: begin
          if (bus.key_hit) begin
            cand_n = bus.key_code;
            stab_n = 4'd1;
            if (DEB_TC == 4'd1) begin
              accept  = 1'b1;
              rel_n   = 4'd0;
              state_n = HELD;
            end else begin
              state_n = CAND;
            end
          end
        end
        CAND: begin
          if (!bus.key_hit) begin
            state_n = IDLE;
          end else if (bus.key_code != cand_q) begin
            cand_n = bus.key_code;
            stab_n = 4'd1;
          end else if (stab_q + 4'd1 == DEB_TC) begin
            stab_n  = DEB_TC;
            accept  = 1'b1;
            rel_n   = 4'd0;
            state_n = HELD;
          end else begin
            stab_n = stab_q + 4'd1;
          end
        end
        HELD: begin
          if (bus.key_hit) begin
            rel_n = 4'd0;
          end else if (rel_q + 4'd1 == REL_TC) begin
            rel_n   = 4'd0;
            state_n = IDLE;
          end else begin
            rel_n = rel_q + 4'd1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign act_num = bus.operand_sel ? num2_q : num1_q;
  assign act_cnt = bus.operand_sel ? cnt2_q : cnt1_q;

  // A clear discards a coincident digit, so a cleared operand never reports overflow.
  always_comb begin
    act_num_n = act_num;
    act_cnt_n = act_cnt;
    ovf_n     = 1'b0;
    if (bus.clr) begin
      act_num_n = 16'h0000;
      act_cnt_n = 3'd0;
    end else if (accept) begin
      if (act_cnt == MAX_DIGITS) begin
        ovf_n = 1'b1;
      end else begin
        act_num_n = {act_num[11:0], bus.key_code};
        act_cnt_n = act_cnt + 3'd1;
      end
    end
  end

  assign num1_n = bus.operand_sel ? num1_q : act_num_n;
  assign cnt1_n = bus.operand_sel ? cnt1_q : act_cnt_n;
  assign num2_n = bus.operand_sel ? act_num_n : num2_q;
  assign cnt2_n = bus.operand_sel ? act_cnt_n : cnt2_q;

  // Decode from next-cycle values so the display lands with the operand update.
  for (genvar k = 0; k < 4; k++) begin : g_digit
    hex_to_7seg u_hex (
      .hex (act_num_n[4*k +: 4]),
      .seg (seg_raw[k])
    );
    assign seg_n[8*k +: 8] = (3'(k) < act_cnt_n) ? seg_raw[k] : SEG_BLANK;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cand_q       <= 4'd0;
      stab_q       <= 4'd0;
      rel_q        <= 4'd0;
      key_accept_q <= 1'b0;
      ovf_q        <= 1'b0;
      key_out_q    <= 4'd0;
      num1_q       <= 16'h0000;
      num2_q       <= 16'h0000;
      cnt1_q       <= 3'd0;
      cnt2_q       <= 3'd0;
      seg_q        <= {4{SEG_BLANK}};
    end else begin
      state_q      <= state_n;
      cand_q       <= cand_n;
      stab_q       <= stab_n;
      rel_q        <= rel_n;
      key_accept_q <= accept;
      ovf_q        <= ovf_n;
      if (accept) key_out_q <= bus.key_code;
      num1_q       <= num1_n;
      num2_q       <= num2_n;
      cnt1_q       <= cnt1_n;
      cnt2_q       <= cnt2_n;
      seg_q        <= seg_n;
    end
  end

  assign bus.key_accept = key_accept_q;
  assign bus.ovf        = ovf_q;
  assign bus.key_out    = key_out_q;
  assign bus.num1       = num1_q;
  assign bus.num2       = num2_q;
  assign bus.cnt1       = cnt1_q;
  assign bus.cnt2       = cnt2_q;
  assign bus.seg_out    = seg_q;

endmodule

// File: tb/tb_keypad_hex_entry.sv
// Directed bench for keypad_hex_entry: debounce, hold/release, entry, overflow, operand select, clear, reset.
module tb_keypad_hex_entry;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   n_acc;
  int   n_ovf;

  keypad_hex_entry_if bus ();

  keypad_hex_entry #(
    .DEBOUNCE_SCANS (3),
    .RELEASE_SCANS  (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One scan result, then one quiet cycle; accept/ovf pulses are tallied.
  task automatic scan(input logic hit, input logic [3:0] code);
    bus.scan_done = 1'b1;
    bus.key_hit   = hit;
    bus.key_code  = code;
    @(posedge clk); #1;
    bus.scan_done = 1'b0;
    bus.key_hit   = 1'b0;
    if (bus.key_accept === 1'b1) n_acc++;
    if (bus.ovf === 1'b1) n_ovf++;
    @(posedge clk); #1;
  endtask

  task automatic press(input logic [3:0] code);
    repeat (3) scan(1'b1, code);
    repeat (2) scan(1'b0, 4'h0);
  endtask

  task automatic pulse_clr();
    bus.clr = 1'b1;
    @(posedge clk); #1;
    bus.clr = 1'b0;
  endtask

  initial begin
    checks = 0; failures = 0; n_acc = 0; n_ovf = 0;
    rst = 1'b1;
    bus.scan_done = 1'b0; bus.key_hit = 1'b0; bus.key_code = 4'h0;
    bus.operand_sel = 1'b0; bus.clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_accept", 32'(bus.key_accept), 32'd0);
    check("rst_ovf", 32'(bus.ovf), 32'd0);
    check("rst_key_out", 32'(bus.key_out), 32'd0);
    check("rst_num1", 32'(bus.num1), 32'd0);
    check("rst_num2", 32'(bus.num2), 32'd0);
    check("rst_cnt1", 32'(bus.cnt1), 32'd0);
    check("rst_seg", bus.seg_out, 32'hFFFF_FFFF);
    rst = 1'b0;
    @(posedge clk); #1;

    // Debounce: two scans are not enough, the third accepts.
    scan(1'b1, 4'h5);
    scan(1'b1, 4'h5);
    check("deb_two_scans", 32'(n_acc), 32'd0);
    bus.scan_done = 1'b1; bus.key_hit = 1'b1; bus.key_code = 4'h5;
    @(posedge clk); #1;
    bus.scan_done = 1'b0; bus.key_hit = 1'b0;
    check("deb_accept_pulse", 32'(bus.key_accept), 32'd1);
    n_acc++;
    @(posedge clk); #1;
    check("deb_accept_single", 32'(bus.key_accept), 32'd0);
    check("deb_key_out", 32'(bus.key_out), 32'h5);
    check("deb_num1", 32'(bus.num1), 32'h0005);
    check("deb_cnt1", 32'(bus.cnt1), 32'd1);
    check("deb_seg", bus.seg_out, 32'hFFFF_FF92);
    repeat (2) scan(1'b0, 4'h0);

    // Bounce: 7,7,9,9,9 accepts only 9.
    pulse_clr();
    n_acc = 0;
    scan(1'b1, 4'h7); scan(1'b1, 4'h7);
    scan(1'b1, 4'h9); scan(1'b1, 4'h9);
    check("bounce_no_early", 32'(n_acc), 32'd0);
    scan(1'b1, 4'h9);
    check("bounce_one_accept", 32'(n_acc), 32'd1);
    check("bounce_num1", 32'(bus.num1), 32'h0009);
    check("bounce_key_out", 32'(bus.key_out), 32'h9);
    repeat (2) scan(1'b0, 4'h0);

    // Hold for 20 scans, release, press again.
    pulse_clr();
    n_acc = 0;
    repeat (20) scan(1'b1, 4'hA);
    check("hold_single_accept", 32'(n_acc), 32'd1);
    scan(1'b0, 4'h0);
    repeat (3) scan(1'b1, 4'hA);
    check("hold_short_release", 32'(n_acc), 32'd1);
    repeat (2) scan(1'b0, 4'h0);
    repeat (3) scan(1'b1, 4'hA);
    check("hold_two_accepts", 32'(n_acc), 32'd2);
    check("hold_num1", 32'(bus.num1), 32'h00AA);
    repeat (2) scan(1'b0, 4'h0);

    // Four digits then overflow.
    pulse_clr();
    n_acc = 0; n_ovf = 0;
    press(4'h1); press(4'h2); press(4'h3); press(4'h4);
    check("entry_no_ovf", 32'(n_ovf), 32'd0);
    press(4'h5);
    check("entry_accepts", 32'(n_acc), 32'd5);
    check("entry_ovf", 32'(n_ovf), 32'd1);
    check("entry_num1", 32'(bus.num1), 32'h1234);
    check("entry_cnt1", 32'(bus.cnt1), 32'd4);
    check("entry_seg", bus.seg_out, 32'hF9A4_B099);

    // Second operand.
    bus.operand_sel = 1'b1;
    @(posedge clk); #1;
    check("sel2_blank", bus.seg_out, 32'hFFFF_FFFF);
    press(4'hE); press(4'hF);
    check("sel2_num2", 32'(bus.num2), 32'h00EF);
    check("sel2_cnt2", 32'(bus.cnt2), 32'd2);
    check("sel2_num1_kept", 32'(bus.num1), 32'h1234);
    check("sel2_seg", bus.seg_out, 32'hFFFF_868E);
    bus.operand_sel = 1'b0;
    @(posedge clk); #1;
    check("sel1_seg", bus.seg_out, 32'hF9A4_B099);

    // Clear coincident with accept.
    n_acc = 0;
    scan(1'b1, 4'h6); scan(1'b1, 4'h6);
    bus.clr = 1'b1;
    scan(1'b1, 4'h6);
    bus.clr = 1'b0;
    check("clr_accept", 32'(n_acc), 32'd1);
    check("clr_num1", 32'(bus.num1), 32'h0000);
    check("clr_cnt1", 32'(bus.cnt1), 32'd0);
    check("clr_seg", bus.seg_out, 32'hFFFF_FFFF);
    check("clr_num2_kept", 32'(bus.num2), 32'h00EF);
    repeat (2) scan(1'b0, 4'h0);

    // Reset mid-CAND, key still held afterwards is a fresh press.
    press(4'h8);
    n_acc = 0;
    scan(1'b1, 4'h3); scan(1'b1, 4'h3);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rstc_num1", 32'(bus.num1), 32'h0000);
    check("rstc_num2", 32'(bus.num2), 32'h0000);
    check("rstc_cnt2", 32'(bus.cnt2), 32'd0);
    check("rstc_key_out", 32'(bus.key_out), 32'h0);
    check("rstc_seg", bus.seg_out, 32'hFFFF_FFFF);
    scan(1'b1, 4'h3); scan(1'b1, 4'h3);
    check("rstc_fresh_wait", 32'(n_acc), 32'd0);
    scan(1'b1, 4'h3);
    check("rstc_fresh_accept", 32'(n_acc), 32'd1);
    check("rstc_fresh_num1", 32'(bus.num1), 32'h0003);
    check("rstc_fresh_seg", bus.seg_out, 32'hFFFF_FFB0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
